uart_receiver: RTL and testbench

//   UART serial-to-parallel receiver: 8N1 format (1 start, 8 data LSB-first, 1 stop, no parity).
//   Mid-bit sampling from a clock-count timebase. Presents each correctly framed byte with a
//   one-cycle done strobe. Sits behind the board RX pin, feeding byte-level consumers.

---
 rtl/uart_receiver.sv | 139 +++++++++++++
 tb/tb_uart_receiver.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver with mid-bit sampling from a clock-count timebase.
// Define UART_RX_SYNC_EN to put a 2-flop synchronizer on input_serial (adds 2 cycles latency).
module uart_receiver #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       input_serial,
   output logic       done,
   output logic [7:0] output_Byte
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int M  = (CLKS_PER_BIT - 1) / 2;
   localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] START_LAST = (M > 0) ? CW'(M - 1) : '0;
   localparam bit            SKIP_START = (M == 0);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START_BIT = 3'd1,
      DATA_BITS = 3'd2,
      STOP_BIT  = 3'd3,
      CLEANUP   = 3'd4
   } state_t;

   state_t        state, state_next;
   logic          rx;
   logic [CW-1:0] cnt, cnt_next;
   logic [2:0]    idx, idx_next;
   logic [7:0]    shift, shift_next;
   logic [7:0]    byte_next;
   logic          done_next;
   logic          err, err_next;

`ifdef UART_RX_SYNC_EN
   logic [1:0] sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= '1;
      else        sync <= {sync[0], input_serial};
   end

   assign rx = sync[1];
`else
   assign rx = input_serial;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (!rx) state_next = SKIP_START ? DATA_BITS : START_BIT;
         START_BIT: if (cnt == START_LAST) state_next = rx ? IDLE : DATA_BITS;
         DATA_BITS: if (cnt == CNT_LAST && idx == 3'd7) state_next = STOP_BIT;
         STOP_BIT:  if (cnt == CNT_LAST) state_next = CLEANUP;
         // A framing error parks here until the line recovers, so a stuck-low line never retriggers.
         CLEANUP:   if (!err || rx) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_comb begin
      cnt_next   = cnt;
      idx_next   = idx;
      shift_next = shift;
      byte_next  = output_Byte;
      done_next  = 1'b0;
      err_next   = err;
      case (state)
         IDLE: begin
            cnt_next = '0;
            idx_next = '0;
         end
         START_BIT: begin
            if (cnt == START_LAST) begin
               cnt_next = '0;
               idx_next = '0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         DATA_BITS: begin
            if (cnt == CNT_LAST) begin
               cnt_next        = '0;
               shift_next[idx] = rx;
               if (idx != 3'd7) idx_next = idx + 3'd1;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         STOP_BIT: begin
            if (cnt == CNT_LAST) begin
               cnt_next = '0;
               if (rx) begin
                  byte_next = shift;
                  done_next = 1'b1;
                  err_next  = 1'b0;
               end else begin
                  err_next  = 1'b1;
               end
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         CLEANUP: begin
            cnt_next = '0;
            if (!err || rx) err_next = 1'b0;
         end
         default: begin
            cnt_next = '0;
            idx_next = '0;
            err_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         idx         <= '0;
         shift       <= '0;
         output_Byte <= '0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         cnt         <= cnt_next;
         idx         <= idx_next;
         shift       <= shift_next;
         output_Byte <= byte_next;
         done        <= done_next;
         err         <= err_next;
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Testbench for uart_receiver: directed and randomized line waveforms checked cycle by cycle
// against a frame-level reference model (CLKS_PER_BIT = 1 and 4 instances).
`timescale 1ns/1ps
module tb_uart_receiver;
`ifdef UART_RX_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in1, in4;
   logic       done1, done4;
   logic [7:0] byte1, byte4;

   always #50 clk = ~clk;

   uart_receiver #(.CLKS_PER_BIT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .input_serial(in1), .done(done1), .output_Byte(byte1)
   );
   uart_receiver #(.CLKS_PER_BIT(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .input_serial(in4), .done(done4), .output_Byte(byte4)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   bit         line[$];
   logic [7:0] carry1, carry4;
   int         seen_done, last_done_idx;
   logic [7:0] first_byte;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic add_level(input bit v, input int n);
      repeat (n) line.push_back(v);
   endtask

   task automatic add_frame(input int cpb, input logic [7:0] d, input bit stop);
      add_level(1'b0, cpb);
      for (int k = 0; k < 8; k++) add_level(d[k], cpb);
      add_level(stop, cpb);
   endtask

   // Reference: walk the sampled line frame by frame using the mid-bit sample arithmetic.
   task automatic run_seg(input int cpb);
      int         n, m, t, s, st, u;
      bit         rx[];
      bit         ev[];
      logic [7:0] evb[];
      logic [7:0] b, cur, ob;
      logic       d;
      add_level(1'b1, 12 * cpb + 4);
      n   = line.size();
      rx  = new[n];
      ev  = new[n];
      evb = new[n];
      for (int i = 0; i < n; i++) begin
         rx[i]  = (i >= LAT) ? line[i - LAT] : 1'b1;
         ev[i]  = 1'b0;
         evb[i] = '0;
      end
      m = (cpb - 1) / 2;
      t = 0;
      while (t < n) begin
         if (rx[t]) begin
            t++;
            continue;
         end
         s = t;
         if (m > 0) begin
            if (s + m >= n) break;
            if (rx[s + m]) begin
               t = s + m + 1;
               continue;
            end
         end
         st = s + m + 9 * cpb;
         if (st >= n) break;
         for (int k = 0; k < 8; k++) b[k] = rx[s + m + (k + 1) * cpb];
         if (rx[st]) begin
            ev[st]  = 1'b1;
            evb[st] = b;
            t = st + 2;
         end else begin
            u = st + 1;
            while (u < n && !rx[u]) u++;
            t = u + 1;
         end
      end
      cur = (cpb == 1) ? carry1 : carry4;
      seen_done     = 0;
      last_done_idx = -1;
      first_byte    = '0;
      for (int i = 0; i <= n; i++) begin
         @(negedge clk);
         if (i > 0) begin
            if (ev[i - 1]) cur = evb[i - 1];
            d  = (cpb == 1) ? done1 : done4;
            ob = (cpb == 1) ? byte1 : byte4;
            check_value($sformatf("done_cpb%0d_c%0d", cpb, i - 1), {31'd0, d}, {31'd0, ev[i - 1]});
            check_value($sformatf("byte_cpb%0d_c%0d", cpb, i - 1), {24'd0, ob}, {24'd0, cur});
            if (d === 1'b1) begin
               if (seen_done == 0) first_byte = ob;
               seen_done++;
               last_done_idx = i - 1;
            end
         end
         if (i < n) begin
            if (cpb == 1) in1 = line[i];
            else          in4 = line[i];
         end
      end
      if (cpb == 1) carry1 = cur;
      else          carry4 = cur;
      line.delete();
   endtask

   task automatic reset_mid_frame();
      add_frame(4, 8'hC3, 1'b1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         in4 = line[i];
      end
      line.delete();
      #20 rst_n = 1'b0;
      #1;
      check_value("rst_mid_done4", {31'd0, done4}, 32'd0);
      check_value("rst_mid_byte4", {24'd0, byte4}, 32'h00);
      check_value("rst_mid_byte1", {24'd0, byte1}, 32'h00);
      @(negedge clk);
      in4 = 1'b1;
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      carry1 = '0;
      carry4 = '0;
   endtask

   initial begin
      int cpb;
      int kind;
      rst_n = 1'b0;
      in1   = 1'b1;
      in4   = 1'b1;
      #1;
      check_value("rst_done1", {31'd0, done1}, 32'd0);
      check_value("rst_byte1", {24'd0, byte1}, 32'h00);
      check_value("rst_done4", {31'd0, done4}, 32'd0);
      check_value("rst_byte4", {24'd0, byte4}, 32'h00);
      repeat (3) @(negedge clk);
      rst_n  = 1'b1;
      carry1 = '0;
      carry4 = '0;

      // One-clock-per-bit frame 0x7F; stop sample lands on cycle 10 (plus synchronizer latency).
      add_level(1'b1, 1);
      add_frame(1, 8'h7F, 1'b1);
      run_seg(1);
      check_value("t2_byte", {24'd0, byte1}, 32'h7F);
      check_value("t2_pulses", seen_done, 1);
      check_value("t2_done_cycle", last_done_idx, 10 + LAT);

      add_level(1'b1, 2);
      add_frame(4, 8'hA5, 1'b1);
      add_frame(4, 8'h3C, 1'b1);
      run_seg(4);
      check_value("t3_pulses", seen_done, 2);
      check_value("t3_first", {24'd0, first_byte}, 32'hA5);
      check_value("t3_last", {24'd0, byte4}, 32'h3C);

      add_level(1'b1, 3);
      add_level(1'b0, 1);
      run_seg(4);
      check_value("t4_pulses", seen_done, 0);
      check_value("t4_byte", {24'd0, byte4}, 32'h3C);

      reset_mid_frame();
      add_level(1'b1, 2);
      add_frame(4, 8'h96, 1'b1);
      run_seg(4);
      check_value("t1_pulses", seen_done, 1);
      check_value("t1_byte", {24'd0, byte4}, 32'h96);

      add_level(1'b1, 2);
      add_frame(4, 8'hE7, 1'b0);
      add_level(1'b0, 40);
      add_level(1'b1, 3);
      add_frame(4, 8'h55, 1'b1);
      run_seg(4);
      check_value("t5_pulses", seen_done, 1);
      check_value("t5_byte", {24'd0, byte4}, 32'h55);

      for (int r = 0; r < 30; r++) begin
         cpb = ($urandom_range(0, 1) == 1) ? 4 : 1;
         add_level(1'b1, int'($urandom_range(1, 4)));
         repeat ($urandom_range(1, 4)) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 6) begin
               add_frame(cpb, 8'($urandom), 1'b1);
            end else if (kind < 8) begin
               add_level(1'b0, 1);
               add_level(1'b1, int'($urandom_range(1, 3)));
            end else begin
               add_frame(cpb, 8'($urandom), 1'b0);
               add_level(1'b0, int'($urandom_range(0, 12)));
               add_level(1'b1, 1);
            end
            add_level(1'b1, int'($urandom_range(0, 3)));
         end
         run_seg(cpb);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
